fxp_stream_sched: RTL and testbench
===================================

FXP_STREAM_SCHED -- requirements
Module: fxp_stream_sched

Interface
REQ-001 SHALL have parameter NUM_MAX, default 48000, the largest allowed run length in samples.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the result buffer depth (power of 2, >= 2).
REQ-003 SHALL have parameter OP_LAT, default 1, the cycles from op_valid to operator result valid.
REQ-004 SHALL have ports: clk in 1 (rising-edge clock); rst in 1 (synchronous, active-high reset).
REQ-005 SHALL have ports: start in 1 (run request); abort in 1 (cancel run); op_sel in 2 (00 add, 01 sub, 10 mul, 11 reserved, treated as add); cfg_len in 16 (sample count).
REQ-006 SHALL have ports: mem_rd_en out 1, mem_addr out 16 (sample read request); mem_a_data in 17 (Q3.14); mem_b_data in 17 (Q5.12), both valid the cycle after mem_rd_en.
REQ-007 SHALL have ports: op_a out 17, op_b out 17, op_valid out 1 (operands to shared add/subtract/mul units); res_add in 18, res_sub in 18, res_mul in 34 (unit results).
REQ-008 SHALL have ports: out_data out 34, out_valid out 1, out_ready in 1 (result stream); busy out 1, done out 1, sample_idx out 16 (next address to issue).

Function
REQ-009 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-010 IDLE: start SHALL latch op_sel and cfg_len; next state RUN if cfg_len != 0, else DONE. start outside IDLE SHALL be ignored.
REQ-011 RUN: mem_rd_en SHALL be registered and asserted when issued < len and (fifo_count + inflight) < FIFO_DEPTH; mem_addr = sample_idx, which then increments by 1.
REQ-012 Go from RUN to DRAIN on the cycle the last read issues; go from DRAIN to DONE when inflight == 0 and the FIFO is empty.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE; busy=1 in RUN and DRAIN only.
REQ-014 Register op_a/op_b from mem data, with op_valid=1, exactly 2 cycles after the corresponding mem_rd_en.
REQ-015 Sample the unit result OP_LAT cycles after op_valid and write it to the FIFO: add/sub sign-extended from 18 to 34 bits, mul unchanged; no Q-format alignment.
REQ-016 inflight SHALL count reads issued but not yet written to the FIFO; the credit rule SHALL guarantee the FIFO never overflows and no result is dropped.
REQ-017 out_valid SHALL equal FIFO non-empty with out_data at the head; pop on out_valid && out_ready; a simultaneous push and pop at full or empty SHALL keep the count correct.
REQ-018 Latency: start in cycle 0 with out_ready=1 and OP_LAT=1 SHALL give mem_rd_en in cycle 1, op_valid in cycle 3, first out_valid in cycle 5, then one result per cycle.
REQ-019 abort in RUN/DRAIN SHALL return to IDLE the next cycle, flush the FIFO, clear inflight, and suppress done; abort in IDLE/DONE SHALL have no effect.
REQ-020 sample_idx SHALL stop at len and never wrap; results SHALL leave in address order.

Reset
REQ-021 rst SHALL force IDLE and clear all counters and the FIFO, from any state, mid-run included.
REQ-022 While rst is high, all outputs SHALL be 0: mem_rd_en, mem_addr, op_a, op_b, op_valid, out_data, out_valid, busy, done, sample_idx.

Structure
REQ-023 Package fxp_sched_pkg SHALL hold the op_sel encodings, the state enum and the width constants (17, 18, 34, 16).
REQ-024 A sub-module res_fifo SHALL implement the synchronous show-ahead FIFO (34-bit, FIFO_DEPTH) with count output.

Verification
REQ-025 ADD, len=4, a=17'h00010, b=17'h00001, out_ready=1 -> four out_data=34'h11 in cycles 5-8; done pulses in cycle 9.
REQ-026 SUB, a=17'h00000, b=17'h00001 (res_sub=18'h3FFFF) -> out_data=34'h3FFFFFFFF (sign extension); MUL, res_mul=34'h3FFFFFFFE -> passed unchanged.
REQ-027 len=10, out_ready=0 -> exactly 4 mem_rd_en pulses, then stall; release out_ready -> 10 results in address order 0-9, no loss or duplicates, then done.
REQ-028 len=0 -> done in cycle 1, no mem_rd_en, no out_valid; start asserted while busy -> ignored, run length unchanged.
REQ-029 abort after 3 issues -> IDLE next cycle, out_valid=0, no done; a new start then runs normally from address 0.
REQ-030 rst asserted mid-DRAIN -> all outputs 0 the next cycle; the next run after reset completes correctly.

Source files
------------

// File: rtl/fxp_sched_pkg.sv
// Shared definitions for the fixed-point stream scheduler.
// Holds the operator-select encodings, the scheduler state enum, the
// datapath width constants and the add/sub result sign-extension helper.
package fxp_sched_pkg;

  localparam int unsigned A_W    = 17;  // operand width (Q3.14 / Q5.12)
  localparam int unsigned ADD_W  = 18;  // add/sub unit result width
  localparam int unsigned RES_W  = 34;  // mul result and output stream width
  localparam int unsigned ADDR_W = 16;  // sample address / length width

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11   // reserved, behaves as add
  } op_sel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [RES_W-1:0] sext_add(input logic [ADD_W-1:0] v);
    return {{(RES_W-ADD_W){v[ADD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Synchronous show-ahead result FIFO.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         drop all entries (same effect as reset on pointers/count)
//   push/push_data write side; a push while full is accepted only with a pop
//   pop           read side; ignored while empty
//   head          entry at the read pointer, valid whenever !empty
//   count, empty  occupancy
module res_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/fxp_stream_sched.sv
// Fixed-point stream scheduler: reads cfg_len sample pairs from memory,
// feeds them to shared add/sub/mul units and streams the selected result
// out through a credit-protected result FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, abort, op_sel, cfg_len run control
//   mem_rd_en, mem_addr           sample read request
//   mem_a_data, mem_b_data        read data, valid the cycle after mem_rd_en
//   op_a, op_b, op_valid          operands to the external units
//   res_add, res_sub, res_mul     unit results, OP_LAT cycles after op_valid
//   out_data, out_valid, out_ready result stream
//   busy, done, sample_idx        status; sample_idx is next address to issue
module fxp_stream_sched
  import fxp_sched_pkg::*;
#(
  parameter int unsigned NUM_MAX    = 48000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OP_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        op_sel,
  input  logic [15:0]       cfg_len,
  output logic              mem_rd_en,
  output logic [15:0]       mem_addr,
  input  logic [16:0]       mem_a_data,
  input  logic [16:0]       mem_b_data,
  output logic [16:0]       op_a,
  output logic [16:0]       op_b,
  output logic              op_valid,
  input  logic [17:0]       res_add,
  input  logic [17:0]       res_sub,
  input  logic [33:0]       res_mul,
  output logic [33:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sample_idx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  state_t              state_nxt;
  op_sel_t             sel_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   len_clamped;
  logic                rd_q;
  logic                rd_d1;
  logic                opv_q;
  logic [OP_LAT-1:0]   lat_sr;
  logic [A_W-1:0]      a_q;
  logic [A_W-1:0]      b_q;
  logic [CNT_W-1:0]    inflight_q;
  logic [CNT_W-1:0]    inflight_nxt;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    count_nxt;
  logic                fifo_empty;
  logic [RES_W-1:0]    fifo_head;
  logic [RES_W-1:0]    push_data;
  logic                push;
  logic                pop;
  logic                start_acc;
  logic                start_go;
  logic                abort_hit;
  logic                credit_ok;
  logic                issue;
  logic                last_issue;
  logic                busy_s;
  logic                done_s;

  assign len_clamped = (32'(cfg_len) > NUM_MAX) ? ADDR_W'(NUM_MAX) : cfg_len;
  assign start_acc   = start && (state == S_IDLE);
  assign start_go    = start_acc && (len_clamped != '0);
  assign abort_hit   = abort && ((state == S_RUN) || (state == S_DRAIN));

  // Credits cover both queued results and reads still in the pipeline,
  // so every issued read is guaranteed a FIFO slot when it arrives.
  assign credit_ok  = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
  // The first read issues on the start edge so it appears in the first
  // RUN cycle.
  assign issue      = !abort_hit &&
                      (start_go || ((state == S_RUN) && (idx_q < len_q) && credit_ok));
  assign last_issue = issue && (state == S_RUN) && ((32'(idx_q) + 32'd1) == 32'(len_q));

  assign push         = lat_sr[OP_LAT-1];
  assign pop          = out_valid && out_ready;
  assign inflight_nxt = inflight_q + CNT_W'(issue) - CNT_W'(push);
  assign count_nxt    = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    push_data = sext_add(res_add);
    case (sel_q)
      OP_SUB:  push_data = sext_add(res_sub);
      OP_MUL:  push_data = res_mul;
      default: push_data = sext_add(res_add);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DRAIN exits on the projected next-cycle occupancy so
  // done lands in the cycle right after the final result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len_clamped != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if ((idx_q >= len_q) || last_issue) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if ((inflight_nxt == '0) && (count_nxt == '0)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state)
      S_RUN, S_DRAIN: busy_s = 1'b1;
      S_DONE:         done_s = 1'b1;
      default: ;
    endcase
  end

  // Read issue, operand staging and result-latency tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      rd_d1      <= '0;
      opv_q      <= '0;
      lat_sr     <= '0;
      inflight_q <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      sel_q      <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
    end else if (abort_hit) begin
      rd_q       <= '0;
      rd_d1      <= '0;
      opv_q      <= '0;
      lat_sr     <= '0;
      inflight_q <= '0;
      idx_q      <= '0;
    end else begin
      rd_q       <= issue;
      rd_d1      <= rd_q;
      opv_q      <= rd_d1;
      lat_sr     <= (lat_sr << 1) | OP_LAT'(opv_q);
      inflight_q <= inflight_nxt;
      if (rd_d1) begin
        a_q <= mem_a_data;
        b_q <= mem_b_data;
      end
      if (start_acc) begin
        len_q  <= len_clamped;
        sel_q  <= op_sel_t'(op_sel);
        addr_q <= '0;
        idx_q  <= start_go ? ADDR_W'(1) : '0;
      end else if (issue) begin
        addr_q <= idx_q;
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_hit),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Outputs are forced low combinationally while reset is held.
  assign mem_rd_en  = rd_q & ~rst;
  assign mem_addr   = rst ? '0 : addr_q;
  assign op_a       = rst ? '0 : a_q;
  assign op_b       = rst ? '0 : b_q;
  assign op_valid   = opv_q & ~rst;
  assign out_valid  = ~fifo_empty & ~rst;
  assign out_data   = rst ? '0 : fifo_head;
  assign busy       = busy_s & ~rst;
  assign done       = done_s & ~rst;
  assign sample_idx = rst ? '0 : idx_q;

endmodule

// File: tb/tb_fxp_stream_sched.sv
module tb_fxp_stream_sched;

  localparam int unsigned PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  op_sel;
  logic [15:0] cfg_len;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [16:0] mem_a_data = '0;
  logic [16:0] mem_b_data = '0;
  logic [16:0] op_a;
  logic [16:0] op_b;
  logic        op_valid;
  logic [17:0] res_add = '0;
  logic [17:0] res_sub = '0;
  logic [33:0] res_mul = '0;
  logic [33:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [15:0] sample_idx;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q [$];
  logic [16:0] mem_a [64];
  logic [16:0] mem_b [64];
  int          rd_cnt = 0;
  int          rd_base = 0;
  int          n_out = 0;
  time         t_start = 0;

  always #(PERIOD/2) clk = ~clk;

  fxp_stream_sched #(
    .NUM_MAX    (48000),
    .FIFO_DEPTH (4),
    .OP_LAT     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .op_sel     (op_sel),
    .cfg_len    (cfg_len),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_a_data (mem_a_data),
    .mem_b_data (mem_b_data),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .res_add    (res_add),
    .res_sub    (res_sub),
    .res_mul    (res_mul),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .sample_idx (sample_idx)
  );

  function automatic longint sx17(input logic [16:0] v);
    return v[16] ? (longint'(v) - 64'sd131072) : longint'(v);
  endfunction

  // Reference: signed arithmetic result expressed in 34 bits.
  function automatic logic [33:0] ref_res(input int op, input logic [16:0] a, input logic [16:0] b);
    longint r;
    case (op)
      1:       r = sx17(a) - sx17(b);
      2:       r = sx17(a) * sx17(b);
      default: r = sx17(a) + sx17(b);
    endcase
    return r[33:0];
  endfunction

  function automatic int cyc_now();
    return int'(($time - t_start) / PERIOD);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // External arithmetic units, one cycle of latency.
  always @(posedge clk) begin
    res_add <= 18'(sx17(op_a) + sx17(op_b));
    res_sub <= 18'(sx17(op_a) - sx17(op_b));
    res_mul <= 34'(sx17(op_a) * sx17(op_b));
  end

  // Sample memory, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_data <= mem_a[mem_addr[5:0]];
      mem_b_data <= mem_b[mem_addr[5:0]];
    end
  end

  // Reads must walk addresses 0,1,2,... within each run.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      chk("mem_addr", 64'(mem_addr), 64'(rd_cnt - rd_base));
      rd_cnt++;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h expected=none at %0t", out_data, $time);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #(PERIOD * 100000);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 17'($urandom);
      mem_b[i] = 17'($urandom);
    end
  endtask

  task automatic do_start(input int op, input int len);
    @(posedge clk);
    #1;
    op_sel  = 2'(op);
    cfg_len = 16'(len);
    start   = 1'b1;
    t_start = $time;
    rd_base = rd_cnt;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(ref_res(op, mem_a[i], mem_b[i]));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, 64'({mem_rd_en, mem_addr, op_valid, out_valid, busy, done, sample_idx}), 64'd0);
    chk({name, "_ops"}, 64'({op_a, op_b}), 64'd0);
    chk({name, "_dat"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    int frd, fop, fov, lov, nov, fdn, n0, dn, r0;
    bit reached;

    rst = 1'b1; start = 1'b0; abort = 1'b0; op_sel = '0; cfg_len = '0; out_ready = 1'b1;
    fill_rand();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // ADD, len=4: latency and timing of results and done
    for (int i = 0; i < 64; i++) begin mem_a[i] = 17'h00010; mem_b[i] = 17'h00001; end
    frd = -1; fop = -1; fov = -1; lov = -1; nov = 0; fdn = -1;
    do_start(0, 4);
    repeat (12) begin
      @(negedge clk);
      if (mem_rd_en && frd < 0) frd = cyc_now();
      if (op_valid && fop < 0) fop = cyc_now();
      if (out_valid) begin
        if (fov < 0) fov = cyc_now();
        lov = cyc_now();
        nov++;
      end
      if (done && fdn < 0) fdn = cyc_now();
    end
    chk("lat_rd", 64'(frd), 64'd1);
    chk("lat_opv", 64'(fop), 64'd3);
    chk("lat_first_out", 64'(fov), 64'd5);
    chk("lat_last_out", 64'(lov), 64'd8);
    chk("lat_n_out", 64'(nov), 64'd4);
    chk("lat_done", 64'(fdn), 64'd9);
    chk("lat_sb_empty", 64'(exp_q.size()), 64'd0);

    // SUB sign extension, then MUL pass-through
    mem_a[0] = 17'h00000; mem_b[0] = 17'h00001;
    do_start(1, 1);
    wait_done(30, 1'b0);
    mem_a[0] = 17'h1FFFF; mem_b[0] = 17'h00002;
    do_start(2, 1);
    wait_done(30, 1'b0);

    // Back-pressure: only FIFO_DEPTH reads may issue
    fill_rand();
    out_ready = 1'b0;
    do_start(2, 10);
    repeat (20) @(negedge clk);
    chk("stall_rd", 64'(rd_cnt - rd_base), 64'd4);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    n0 = n_out;
    @(posedge clk); #1; out_ready = 1'b1;
    wait_done(100, 1'b0);
    chk("stall_nout", 64'(n_out - n0), 64'd10);

    // Zero length
    n0 = n_out; fdn = -1; nov = 0;
    do_start(0, 0);
    repeat (6) begin
      @(negedge clk);
      if (done && fdn < 0) fdn = cyc_now();
      if (out_valid) nov++;
    end
    chk("len0_done", 64'(fdn), 64'd1);
    chk("len0_rd", 64'(rd_cnt - rd_base), 64'd0);
    chk("len0_out", 64'(nov), 64'd0);

    // start while busy is ignored
    fill_rand();
    n0 = n_out;
    do_start(0, 5);
    @(posedge clk); #1; start = 1'b1; cfg_len = 16'd9; op_sel = 2'b10;
    @(posedge clk); #1; start = 1'b0;
    wait_done(60, 1'b0);
    chk("busy_idx", 64'(sample_idx), 64'd5);
    chk("busy_nout", 64'(n_out - n0), 64'd5);

    // Abort after three issues
    fill_rand();
    out_ready = 1'b0;
    do_start(1, 8);
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rd_cnt - rd_base >= 3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reach", 64'(reached), 64'd1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    dn = 0; r0 = rd_cnt;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_nodone", 64'(dn), 64'd0);
    chk("abort_no_rd", 64'(rd_cnt - r0), 64'd0);
    out_ready = 1'b1;
    fill_rand();
    do_start(0, 6);
    wait_done(60, 1'b0);

    // Reset during DRAIN
    fill_rand();
    do_start(0, 3);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_no_rd", 64'(mem_rd_en), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("midrst_next");
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    fill_rand();
    do_start(3, 7);
    wait_done(60, 1'b0);

    // Randomized runs with random back-pressure
    for (int k = 0; k < 10; k++) begin
      fill_rand();
      do_start(int'($urandom_range(0, 3)), int'($urandom_range(1, 24)));
      wait_done(400, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
